// File: rtl/strela_seq_pkg.sv
// Shared types and register map for the accelerator execution sequencer.
package strela_seq_pkg;

  // Sequencer phases; the encoding is visible in STATUS[9:8].
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CFG     = 2'd1,
    ST_EXEC    = 2'd2,
    ST_CAPTURE = 2'd3
  } seq_state_e;

  // Register word indices.
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_CYC_CFG   = 3'd2;
  localparam logic [2:0] REG_CYC_EXEC  = 3'd3;
  localparam logic [2:0] REG_CYC_STALL = 3'd4;

  // CTRL write bits.
  localparam int CTRL_LOAD_CFG   = 0;
  localparam int CTRL_START_EXEC = 1;
  localparam int CTRL_IRQ_EN     = 2;
  localparam int CTRL_IRQ_CLR    = 3;

  // STATUS read bits.
  localparam int STAT_BUSY_CFG   = 0;
  localparam int STAT_BUSY_EXEC  = 1;
  localparam int STAT_CFG_DONE   = 2;
  localparam int STAT_EXEC_DONE  = 3;
  localparam int STAT_TIMEOUT    = 4;
  localparam int STAT_CMD_ERR    = 5;
  localparam int STAT_IRQ_PEND   = 6;
  localparam int STAT_IRQ_EN     = 7;
  localparam int STAT_STATE_LSB  = 8;
  localparam int STAT_STATE_MSB  = 9;

endpackage

// File: rtl/strela_exec_sequencer.sv
// Bus-side initiator for the accelerator control unit: turns software CTRL
// writes into level commands, waits for the done flags (done must be seen low
// before a high counts), snapshots the perf counters and raises an interrupt.
//
// Register port handshake: a request is accepted in the cycle req_i is high
// (gnt_o mirrors req_i); exactly one cycle later rvalid_o pulses for one cycle
// with rdata_o (read data, or 0 for writes and unmapped words).
module strela_exec_sequencer
  import strela_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [2:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic             gnt_o,
  output logic             rvalid_o,
  output logic [31:0]      rdata_o,
  output logic             load_configuration_o,
  output logic             start_execution_o,
  input  logic             data_config_done_i,
  input  logic             data_output_done_i,
  input  logic [CNT_W-1:0] cycle_count_load_config_i,
  input  logic [CNT_W-1:0] cycle_count_execute_i,
  input  logic [CNT_W-1:0] cycle_count_stall_i,
  output logic             irq_o,
  output seq_state_e       dbg_state_o
);

  localparam bit              WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  seq_state_e       state_q, state_d;
  logic             chain_q, seen_low_q, phase_exec_q;
  logic [CNT_W-1:0] wd_cnt_q;
  logic             cfg_done_q, exec_done_q, timeout_q, cmd_err_q;
  logic             irq_pend_q, irq_en_q;
  logic [CNT_W-1:0] snap_cfg_q, snap_exec_q, snap_stall_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;

  logic        ctrl_wr, cmd_load, cmd_start, cmd_any;
  logic        in_phase, done_in, wd_expire;
  logic        enter_cfg, enter_exec, cmd_accept, timeout_hit;
  logic        irq_set, irq_clr;
  logic [31:0] status_word, rd_data;
  logic [27:0] unused_wdata;

  assign unused_wdata = wdata_i[31:4];

  assign ctrl_wr   = req_i && we_i && (addr_i == REG_CTRL);
  assign cmd_load  = ctrl_wr && wdata_i[CTRL_LOAD_CFG];
  assign cmd_start = ctrl_wr && wdata_i[CTRL_START_EXEC];
  assign cmd_any   = cmd_load || cmd_start;

  assign in_phase  = (state_q == ST_CFG) || (state_q == ST_EXEC);
  // phase_exec_q is only meaningful while a phase is running
  assign done_in   = phase_exec_q ? data_output_done_i : data_config_done_i;
  assign wd_expire = WD_EN && (wd_cnt_q == WD_LAST);

  assign irq_set = (state_q == ST_CAPTURE) || timeout_hit;
  assign irq_clr = ctrl_wr && wdata_i[CTRL_IRQ_CLR];

  // Commands are decoded straight from the state so reset drops them on the same edge
  assign load_configuration_o = (state_q == ST_CFG);
  assign start_execution_o    = (state_q == ST_EXEC);
  assign irq_o                = irq_pend_q && irq_en_q;
  assign gnt_o                = req_i;
  assign rvalid_o             = rvalid_q;
  assign rdata_o              = rdata_q;
  assign dbg_state_o          = state_q;

  // Next-state logic and the one-cycle event strobes that drive the datapath
  always_comb begin
    state_d     = state_q;
    enter_cfg   = 1'b0;
    enter_exec  = 1'b0;
    cmd_accept  = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_load) begin
          state_d    = ST_CFG;
          enter_cfg  = 1'b1;
          cmd_accept = 1'b1;
        end else if (cmd_start) begin
          state_d    = ST_EXEC;
          enter_exec = 1'b1;
          cmd_accept = 1'b1;
        end
      end
      ST_CFG, ST_EXEC: begin
        // A completion in the same cycle as the watchdog limit still counts
        if (done_in && seen_low_q) begin
          state_d = ST_CAPTURE;
        end else if (wd_expire) begin
          state_d     = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (!phase_exec_q && chain_q) begin
          state_d    = ST_EXEC;
          enter_exec = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase bookkeeping: state, chain flag, done-low tracking and watchdog
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      chain_q      <= 1'b0;
      seen_low_q   <= 1'b0;
      phase_exec_q <= 1'b0;
      wd_cnt_q     <= '0;
    end else begin
      state_q <= state_d;

      if (enter_cfg) begin
        chain_q <= cmd_start;
      end else if ((state_q == ST_CAPTURE) || timeout_hit) begin
        chain_q <= 1'b0;
      end

      if (enter_cfg) begin
        phase_exec_q <= 1'b0;
      end else if (enter_exec) begin
        phase_exec_q <= 1'b1;
      end

      if (enter_cfg || enter_exec) begin
        seen_low_q <= 1'b0;
      end else if (in_phase && !done_in) begin
        seen_low_q <= 1'b1;
      end

      if (enter_cfg || enter_exec) begin
        wd_cnt_q <= '0;
      end else if (in_phase) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
    end
  end

  // Sticky status, interrupt state and counter snapshots
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_done_q   <= 1'b0;
      exec_done_q  <= 1'b0;
      timeout_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      irq_pend_q   <= 1'b0;
      irq_en_q     <= 1'b0;
      snap_cfg_q   <= '0;
      snap_exec_q  <= '0;
      snap_stall_q <= '0;
    end else begin
      // An accepted command starts a fresh run, so old results are cleared
      if (cmd_accept) begin
        cfg_done_q  <= 1'b0;
        exec_done_q <= 1'b0;
        timeout_q   <= 1'b0;
        cmd_err_q   <= 1'b0;
      end
      if (cmd_any && (state_q != ST_IDLE)) begin
        cmd_err_q <= 1'b1;
      end
      if (state_q == ST_CAPTURE) begin
        if (phase_exec_q) begin
          exec_done_q <= 1'b1;
        end else begin
          cfg_done_q <= 1'b1;
        end
        snap_cfg_q   <= cycle_count_load_config_i;
        snap_exec_q  <= cycle_count_execute_i;
        snap_stall_q <= cycle_count_stall_i;
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end

      if (ctrl_wr) begin
        irq_en_q <= wdata_i[CTRL_IRQ_EN];
      end
      // A new event wins over a clear in the same cycle
      if (irq_set) begin
        irq_pend_q <= 1'b1;
      end else if (irq_clr) begin
        irq_pend_q <= 1'b0;
      end
    end
  end

  // STATUS word assembly
  always_comb begin
    status_word                                 = '0;
    status_word[STAT_BUSY_CFG]                  = (state_q == ST_CFG);
    status_word[STAT_BUSY_EXEC]                 = (state_q == ST_EXEC);
    status_word[STAT_CFG_DONE]                  = cfg_done_q;
    status_word[STAT_EXEC_DONE]                 = exec_done_q;
    status_word[STAT_TIMEOUT]                   = timeout_q;
    status_word[STAT_CMD_ERR]                   = cmd_err_q;
    status_word[STAT_IRQ_PEND]                  = irq_pend_q;
    status_word[STAT_IRQ_EN]                    = irq_en_q;
    status_word[STAT_STATE_MSB:STAT_STATE_LSB]  = state_q;
  end

  // Read mux; CTRL is command-only and reads back as 0
  always_comb begin
    rd_data = '0;
    case (addr_i)
      REG_STATUS:    rd_data = status_word;
      REG_CYC_CFG:   rd_data = 32'(snap_cfg_q);
      REG_CYC_EXEC:  rd_data = 32'(snap_exec_q);
      REG_CYC_STALL: rd_data = 32'(snap_stall_q);
      default:       rd_data = '0;
    endcase
  end

  // Register-port response, one cycle after the grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= (req_i && !we_i) ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_strela_exec_sequencer.sv
// Self-checking bench for strela_exec_sequencer (watchdog limit 8 cycles).
module tb_strela_exec_sequencer;

  logic        clk_i;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [2:0]  addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        load_configuration_o;
  logic        start_execution_o;
  logic        data_config_done_i;
  logic        data_output_done_i;
  logic [31:0] cnt_cfg, cnt_exec, cnt_stall;
  logic        irq_o;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        req_seen;

  // reference model of the software-visible state
  logic        m_cfg_done, m_exec_done, m_timeout, m_cmd_err, m_irq_pend, m_irq_en;
  logic [31:0] m_snap_cfg, m_snap_exec, m_snap_stall;

  strela_exec_sequencer #(
    .TIMEOUT_CYCLES(8),
    .CNT_W(32)
  ) dut (
    .clk_i                     (clk_i),
    .rst_i                     (rst_i),
    .req_i                     (req_i),
    .we_i                      (we_i),
    .addr_i                    (addr_i),
    .wdata_i                   (wdata_i),
    .gnt_o                     (gnt_o),
    .rvalid_o                  (rvalid_o),
    .rdata_o                   (rdata_o),
    .load_configuration_o      (load_configuration_o),
    .start_execution_o         (start_execution_o),
    .data_config_done_i        (data_config_done_i),
    .data_output_done_i        (data_output_done_i),
    .cycle_count_load_config_i (cnt_cfg),
    .cycle_count_execute_i     (cnt_exec),
    .cycle_count_stall_i       (cnt_stall),
    .irq_o                     (irq_o),
    .dbg_state_o               (dbg_state)
  );

  // clock / global time limit
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic cmd_now(input bit exec);
    return exec ? start_execution_o : load_configuration_o;
  endfunction

  task automatic set_done(input bit exec, input logic v);
    if (exec) data_output_done_i = v;
    else      data_config_done_i = v;
  endtask

  function automatic logic [31:0] status_exp(input logic [1:0] st);
    return {22'd0, st, m_irq_en, m_irq_pend, m_cmd_err, m_timeout,
            m_exec_done, m_cfg_done, (st == 2'd2), (st == 2'd1)};
  endfunction

  // one register access; the expected response goes to the scoreboard
  task automatic reg_access(input string tag, input logic we, input logic [2:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_rd);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wd;
    exp_q.push_back(exp_rd);
    tag_q.push_back(tag);
    #1;
    check_eq("gnt", gnt_o, 1);
    tick();
    req_i   = 1'b0;
    we_i    = 1'b0;
    wdata_i = 32'd0;
  endtask

  task automatic read_status(input string tag, input logic [1:0] st);
    reg_access(tag, 1'b0, 3'd1, 32'd0, status_exp(st));
  endtask

  // CTRL write plus model update; idle says whether the sequencer will accept a command
  task automatic cpu_ctrl(input logic [31:0] d, input bit idle);
    reg_access("ctrl_wr", 1'b1, 3'd0, d, 32'd0);
    if (d[0] || d[1]) begin
      if (idle) begin
        m_cfg_done = 0; m_exec_done = 0; m_timeout = 0; m_cmd_err = 0;
      end else begin
        m_cmd_err = 1;
      end
    end
    m_irq_en = d[2];
    if (d[3]) m_irq_pend = 0;
  endtask

  // Runs one phase from its first command-high cycle through the capture edge.
  task automatic run_phase(input bit exec, input bit inject_reject, input int pre_high,
                           input int low_cyc, input bit clr_at_capture);
    int high_cnt;
    int exp_len;
    high_cnt = 0;
    exp_len  = 1 + (inject_reject ? 1 : 0) + pre_high + low_cyc;
    if (cmd_now(exec)) high_cnt++;
    if (inject_reject) begin
      cpu_ctrl(32'h2, 1'b0);
      check_eq("reject_no_start", start_execution_o, 0);
      if (cmd_now(exec)) high_cnt++;
    end
    repeat (pre_high) begin
      tick();
      if (cmd_now(exec)) high_cnt++;
    end
    set_done(exec, 1'b0);
    repeat (low_cyc) begin
      tick();
      if (cmd_now(exec)) high_cnt++;
    end
    cnt_cfg   = $urandom;
    cnt_exec  = $urandom;
    cnt_stall = $urandom_range(0, 1000);
    set_done(exec, 1'b1);
    tick();
    check_eq(exec ? "exec_len" : "cfg_len", high_cnt, exp_len);
    check_eq("cmds_low_in_capture", {load_configuration_o, start_execution_o}, 0);
    m_snap_cfg   = cnt_cfg;
    m_snap_exec  = cnt_exec;
    m_snap_stall = cnt_stall;
    if (exec) m_exec_done = 1;
    else      m_cfg_done  = 1;
    if (clr_at_capture) cpu_ctrl({28'd0, 1'b1, m_irq_en, 2'b00}, 1'b0);
    else                tick();
    m_irq_pend = 1;
    cnt_cfg   = $urandom;
    cnt_exec  = $urandom;
    cnt_stall = $urandom;
  endtask

  // scoreboard: response timing and data
  always @(posedge clk_i) req_seen <= req_i && !rst_i;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rvalid_o || req_seen) check_eq("rvalid_timing", rvalid_o, req_seen);
      if (rvalid_o) begin
        if (exp_q.size() == 0) begin
          check_eq("rvalid_unexpected", rvalid_o, 0);
        end else begin
          check_eq(tag_q.pop_front(), rdata_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int high;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 3'd0; wdata_i = 32'd0;
    data_config_done_i = 1'b1; data_output_done_i = 1'b1;
    cnt_cfg = 32'd0; cnt_exec = 32'd0; cnt_stall = 32'd0;
    {m_cfg_done, m_exec_done, m_timeout, m_cmd_err, m_irq_pend, m_irq_en} = '0;
    m_snap_cfg = 0; m_snap_exec = 0; m_snap_stall = 0;
    repeat (3) tick();
    check_eq("rst_cmds", {load_configuration_o, start_execution_o}, 0);
    check_eq("rst_irq", irq_o, 0);
    check_eq("rst_rvalid", rvalid_o, 0);
    check_eq("rst_state", dbg_state, 0);
    rst_i = 1'b0;
    cnt_cfg = $urandom; cnt_exec = $urandom; cnt_stall = $urandom;
    read_status("rst_status", 2'd0);
    reg_access("rst_cyc_cfg", 1'b0, 3'd2, 32'd0, 32'd0);

    // single config load: done 1 -> 0 (3 cycles) -> 1
    cpu_ctrl(32'h1, 1'b1);
    check_eq("t1_state_cfg", dbg_state, 1);
    run_phase(1'b0, 1'b0, 0, 3, 1'b0);
    check_eq("t1_irq_masked", irq_o, 0);
    read_status("t1_status", 2'd0);
    reg_access("t1_cyc_cfg", 1'b0, 3'd2, 32'd0, m_snap_cfg);
    reg_access("t1_cyc_exec", 1'b0, 3'd3, 32'd0, m_snap_exec);

    // chained config -> execute with irq enabled; IRQ_CLR collides with the exec capture
    cpu_ctrl(32'h8, 1'b1);
    check_eq("t2_irq_cleared", irq_o, 0);
    cpu_ctrl(32'h7, 1'b1);
    run_phase(1'b0, 1'b0, 1, 2, 1'b0);
    check_eq("t2_exec_started", start_execution_o, 1);
    check_eq("t2_irq_after_cfg", irq_o, 1);
    run_phase(1'b1, 1'b0, 0, 2, 1'b1);
    check_eq("t2_exec_dropped", start_execution_o, 0);
    check_eq("t2_irq_set_wins", irq_o, 1);
    reg_access("t2_cyc_exec", 1'b0, 3'd3, 32'd0, m_snap_exec);
    reg_access("t2_cyc_stall", 1'b0, 3'd4, 32'd0, m_snap_stall);
    read_status("t2_status", 2'd0);

    // done already high on entry must not complete the phase
    cpu_ctrl(32'h1, 1'b1);
    run_phase(1'b0, 1'b0, 3, 2, 1'b0);
    read_status("t5_status", 2'd0);

    // START written while in CFG is rejected
    cpu_ctrl(32'h1, 1'b1);
    run_phase(1'b0, 1'b1, 0, 2, 1'b0);
    check_eq("t4_no_exec", start_execution_o, 0);
    read_status("t4_status", 2'd0);

    // register port corner cases and IRQ enable/clear
    reg_access("wr_status_ignored", 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd0);
    read_status("status_unchanged", 2'd0);
    reg_access("wr_cyc_ignored", 1'b1, 3'd2, 32'hDEAD_BEEF, 32'd0);
    reg_access("cyc_cfg_kept", 1'b0, 3'd2, 32'd0, m_snap_cfg);
    reg_access("unmapped_rd", 1'b0, 3'd6, 32'd0, 32'd0);
    cpu_ctrl(32'h4, 1'b1);
    check_eq("irq_enable", irq_o, 1);
    cpu_ctrl(32'hC, 1'b1);
    check_eq("irq_clear", irq_o, 0);
    read_status("irq_status", 2'd0);

    // watchdog: config done never returns
    cpu_ctrl(32'h1, 1'b1);
    data_config_done_i = 1'b0;
    high = 0;
    for (int i = 0; i < 20; i++) begin
      if (!load_configuration_o) break;
      high++;
      tick();
    end
    check_eq("t3_timeout_len", high, 8);
    m_timeout = 1;
    m_irq_pend = 1;
    read_status("t3_status", 2'd0);
    reg_access("t3_no_snapshot", 1'b0, 3'd2, 32'd0, m_snap_cfg);
    data_config_done_i = 1'b1;

    // reset in the middle of an execute phase
    cpu_ctrl(32'h6, 1'b1);
    check_eq("t6_exec_on", start_execution_o, 1);
    check_eq("t6_irq_before", irq_o, 1);
    data_output_done_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    check_eq("t6_exec_dropped", start_execution_o, 0);
    check_eq("t6_irq_reset", irq_o, 0);
    rst_i = 1'b0;
    data_output_done_i = 1'b1;
    {m_cfg_done, m_exec_done, m_timeout, m_cmd_err, m_irq_pend, m_irq_en} = '0;
    m_snap_cfg = 0; m_snap_exec = 0; m_snap_stall = 0;
    read_status("t6_status", 2'd0);
    reg_access("t6_cyc_cfg", 1'b0, 3'd2, 32'd0, 32'd0);
    reg_access("t6_cyc_stall", 1'b0, 3'd4, 32'd0, 32'd0);

    repeat (3) tick();
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
